alu_operand_stack: RTL and testbench

- Operand stack and sequencer that sits directly upstream of the 16-bit ALU.
- Holds a LIFO of 16-bit words and accepts PUSH/POP/DUP/ALU commands over a valid/ready handshake.
- Drives the ALU operands: top of stack on alu_a, next-of-stack on alu_b, function code on alu_f.
- Writes the ALU result back onto the stack. Flags underflow, overflow and illegal function codes.

---
 rtl/alu_operand_stack.sv | 174 +++++++++++++++++
 tb/tb_alu_operand_stack.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stack.sv
// Operand stack and sequencer feeding the 16-bit ALU.
// LIFO of 16-bit words; PUSH/POP/DUP/ALU over valid/ready.
module alu_operand_stack #(
  parameter int DEPTH = 8,
  parameter int DW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_kind,
  input  logic [15:0]   cmd_data,
  input  logic [4:0]    cmd_func,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  output logic [4:0]    alu_f,
  input  logic [15:0]   alu_s,
  output logic [15:0]   tos,
  output logic [DW-1:0] depth,
  output logic          err,
  output logic [1:0]    err_code,
  input  logic          err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] K_PUSH = 2'b00;
  localparam logic [1:0] K_POP  = 2'b01;
  localparam logic [1:0] K_ALU  = 2'b10;
  localparam logic [1:0] K_DUP  = 2'b11;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_UNDER = 2'b01;
  localparam logic [1:0] E_OVER  = 2'b10;
  localparam logic [1:0] E_ILL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ERROR
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_stack [DEPTH];
  logic [DW-1:0] r_sp;
  logic [4:0]    r_alu_f;
  logic [1:0]    r_err_code;

  logic          w_accept;
  logic          w_empty;
  logic          w_lt2;
  logic          w_full;
  logic          w_unary;
  logic          w_exec_unary;
  logic          w_ok;
  logic [1:0]    w_err;
  logic [DW-1:0] w_sp_m1;
  logic [DW-1:0] w_sp_m2;
  logic [AW-1:0] w_i0;
  logic [AW-1:0] w_i1;
  logic [AW-1:0] w_i2;
  logic [15:0]   w_top;
  logic [15:0]   w_nxt;

  assign w_sp_m1      = r_sp - DW'(1);
  assign w_sp_m2      = r_sp - DW'(2);
  assign w_i0         = r_sp[AW-1:0];
  assign w_i1         = w_sp_m1[AW-1:0];
  assign w_i2         = w_sp_m2[AW-1:0];
  assign w_empty      = (r_sp == '0);
  assign w_lt2        = (r_sp < DW'(2));
  assign w_full       = (r_sp == DW'(DEPTH));
  assign w_unary      = cmd_func[4];
  assign w_exec_unary = r_alu_f[4];
  assign w_top        = w_empty ? 16'h0 : r_stack[w_i1];
  assign w_nxt        = w_lt2 ? 16'h0 : r_stack[w_i2];
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_ok         = (r_state == S_IDLE) && w_accept
                        && (w_err == E_NONE);

  // Classify the offered command; illegal func beats underflow.
  always_comb begin
    w_err = E_NONE;
    unique case (cmd_kind)
      K_PUSH: if (w_full) w_err = E_OVER;
      K_POP:  if (w_empty) w_err = E_UNDER;
      K_DUP: begin
        if (w_empty)     w_err = E_UNDER;
        else if (w_full) w_err = E_OVER;
      end
      K_ALU: begin
        if (cmd_func > 5'd18)
          w_err = E_ILL;
        else if (w_unary ? w_empty : w_lt2)
          w_err = E_UNDER;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err != E_NONE)      w_next = S_ERROR;
          else if (cmd_kind == K_ALU) w_next = S_EXEC;
        end
      end
      S_EXEC:  w_next = S_IDLE;
      S_ERROR: if (err_clr) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registers.
  always_comb begin
    cmd_ready = (r_state != S_EXEC);
    err       = (r_state == S_ERROR);
    err_code  = r_err_code;
    alu_a     = w_top;
    alu_b     = w_nxt;
    tos       = w_top;
    alu_f     = r_alu_f;
    depth     = r_sp;
  end

  // Depth, latched function code and error code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp       <= '0;
      r_alu_f    <= '0;
      r_err_code <= E_NONE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept && w_err != E_NONE) begin
            r_err_code <= w_err;
          end else if (w_accept) begin
            unique case (cmd_kind)
              K_PUSH: r_sp    <= r_sp + DW'(1);
              K_DUP:  r_sp    <= r_sp + DW'(1);
              K_POP:  r_sp    <= w_sp_m1;
              K_ALU:  r_alu_f <= cmd_func;
            endcase
          end
        end
        S_EXEC:  if (!w_exec_unary) r_sp <= w_sp_m1;
        S_ERROR: if (err_clr) r_err_code <= E_NONE;
        default: ;
      endcase
    end
  end

  // Stack storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_ok && cmd_kind == K_PUSH) begin
      r_stack[w_i0] <= cmd_data;
    end else if (w_ok && cmd_kind == K_DUP) begin
      r_stack[w_i0] <= w_top;
    end else if (r_state == S_EXEC) begin
      if (w_exec_unary) r_stack[w_i1] <= alu_s;
      else              r_stack[w_i2] <= alu_s;
    end
  end

endmodule

// File: tb/tb_alu_operand_stack.sv
// Directed bench for alu_operand_stack.
// Small ALU model drives alu_s; expectations hand-computed.
module tb_alu_operand_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_kind;
  logic [15:0] cmd_data;
  logic [4:0]  cmd_func;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_f;
  logic [15:0] alu_s;
  logic [15:0] tos;
  logic [4:0]  depth;
  logic        err;
  logic [1:0]  err_code;
  logic        err_clr;

  int n_pass = 0;
  int n_chk  = 0;

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] ALU  = 2'b10;
  localparam logic [1:0] DUP  = 2'b11;

  alu_operand_stack #(.DEPTH(8), .DW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_kind  (cmd_kind),
    .cmd_data  (cmd_data),
    .cmd_func  (cmd_func),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_s     (alu_s),
    .tos       (tos),
    .depth     (depth),
    .err       (err),
    .err_code  (err_code),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Minimal ALU: b is next-of-stack, a is top.
  always_comb begin
    case (alu_f)
      5'd0:    alu_s = alu_b + alu_a;
      5'd1:    alu_s = alu_b - alu_a;
      5'd2:    alu_s = alu_b * alu_a;
      5'd12:   alu_s = {15'h0, $signed(alu_a) >= $signed(alu_b)};
      5'd16:   alu_s = -alu_a;
      5'd17:   alu_s = ~alu_a;
      default: alu_s = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0]  k,
                      input logic [15:0] d,
                      input logic [4:0]  f);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_kind  = k;
    cmd_data  = d;
    cmd_func  = f;
    while (!cmd_ready && n < 8) begin
      step();
      n++;
    end
    if (!cmd_ready) check("ready_wait", {15'h0, cmd_ready}, 16'h1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_kind  = PUSH;
    cmd_data  = '0;
    cmd_func  = '0;
    err_clr   = 1'b0;
    #12;
    rst_n = 1'b1;
    step();

    check("rst_depth", 16'(depth), 16'd0);
    check("rst_err", {15'h0, err}, 16'd0);
    check("rst_code", {14'h0, err_code}, 16'd0);
    check("rst_ready", {15'h0, cmd_ready}, 16'd1);
    check("rst_aluf", {11'h0, alu_f}, 16'd0);
    check("rst_tos", tos, 16'd0);
    check("rst_alub", alu_b, 16'd0);

    // 40 - 10 via SUB
    send(PUSH, 16'd40, 5'd0);
    send(PUSH, 16'd10, 5'd0);
    check("push2_depth", 16'(depth), 16'd2);
    send(ALU, 16'd0, 5'd1);
    check("sub_ready", {15'h0, cmd_ready}, 16'd0);
    check("sub_a", alu_a, 16'd10);
    check("sub_b", alu_b, 16'd40);
    check("sub_f", {11'h0, alu_f}, 16'd1);
    step();
    check("sub_tos", tos, 16'd30);
    check("sub_depth", 16'(depth), 16'd1);
    check("sub_ready2", {15'h0, cmd_ready}, 16'd1);
    send(DUP, 16'd0, 5'd0);
    check("dup_depth", 16'(depth), 16'd2);
    check("dup_b", alu_b, 16'd30);
    send(POP, 16'd0, 5'd0);
    send(POP, 16'd0, 5'd0);
    check("pop_depth", 16'(depth), 16'd0);
    check("pop_tos", tos, 16'd0);

    // GE then NEG
    send(PUSH, 16'hFFFF, 5'd0);
    send(PUSH, 16'd1, 5'd0);
    send(ALU, 16'd0, 5'd12);
    step();
    check("ge_tos", tos, 16'd1);
    check("ge_depth", 16'(depth), 16'd1);
    send(ALU, 16'd0, 5'd16);
    step();
    check("neg_tos", tos, 16'hFFFF);
    check("neg_depth", 16'(depth), 16'd1);
    step();
    check("aluf_hold", {11'h0, alu_f}, 16'd16);

    // underflow, discard in ERROR, clear
    do_reset();
    send(POP, 16'd0, 5'd0);
    check("uf_err", {15'h0, err}, 16'd1);
    check("uf_code", {14'h0, err_code}, 16'd1);
    check("uf_depth", 16'(depth), 16'd0);
    send(PUSH, 16'd5, 5'd0);
    check("disc_depth", 16'(depth), 16'd0);
    check("disc_ready", {15'h0, cmd_ready}, 16'd1);
    clear_err();
    check("clr_err", {15'h0, err}, 16'd0);
    check("clr_code", {14'h0, err_code}, 16'd0);
    send(PUSH, 16'd5, 5'd0);
    check("clr_depth", 16'(depth), 16'd1);
    check("clr_tos", tos, 16'd5);

    // overflow
    do_reset();
    for (int i = 1; i <= 8; i++) send(PUSH, 16'(i), 5'd0);
    check("full_depth", 16'(depth), 16'd8);
    check("full_err", {15'h0, err}, 16'd0);
    send(PUSH, 16'd9, 5'd0);
    check("of_code", {14'h0, err_code}, 16'd2);
    check("of_tos", tos, 16'd8);
    check("of_depth", 16'(depth), 16'd8);
    send(DUP, 16'd0, 5'd0);
    check("of_dup_depth", 16'(depth), 16'd8);
    check("of_dup_code", {14'h0, err_code}, 16'd2);
    clear_err();
    check("of_keep_depth", 16'(depth), 16'd8);

    // illegal function
    do_reset();
    send(PUSH, 16'd3, 5'd0);
    send(PUSH, 16'd4, 5'd0);
    send(ALU, 16'd0, 5'b10101);
    check("ill_code", {14'h0, err_code}, 16'd3);
    check("ill_depth", 16'(depth), 16'd2);
    check("ill_tos", tos, 16'd4);
    check("ill_aluf", {11'h0, alu_f}, 16'd0);
    do_reset();
    send(ALU, 16'd0, 5'b10101);
    check("ill_wins", {14'h0, err_code}, 16'd3);
    do_reset();
    send(PUSH, 16'd3, 5'd0);
    send(ALU, 16'd0, 5'd0);
    check("bin_uf_code", {14'h0, err_code}, 16'd1);
    check("bin_uf_depth", 16'(depth), 16'd1);

    // back-to-back MUL with queued PUSH, then reset mid-EXEC
    do_reset();
    send(PUSH, 16'd2, 5'd0);
    send(PUSH, 16'd3, 5'd0);
    cmd_valid = 1'b1;
    cmd_kind  = ALU;
    cmd_func  = 5'd2;
    step();
    cmd_kind = PUSH;
    cmd_data = 16'd7;
    check("mul_ready", {15'h0, cmd_ready}, 16'd0);
    step();
    check("mul_tos", tos, 16'd6);
    check("mul_depth", 16'(depth), 16'd1);
    step();
    cmd_valid = 1'b0;
    check("q_tos", tos, 16'd7);
    check("q_depth", 16'(depth), 16'd2);
    send(ALU, 16'd0, 5'd0);
    check("add_ready", {15'h0, cmd_ready}, 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_depth", 16'(depth), 16'd0);
    check("abort_ready", {15'h0, cmd_ready}, 16'd1);
    rst_n = 1'b1;
    step();
    check("abort_hold", 16'(depth), 16'd0);
    check("abort_err", {15'h0, err}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
